// File: rtl/adder_nibble_seq.sv
// Wide adder that time-multiplexes one external 4-bit ripple adder, one nibble per clock, LSB first.
// Optional ADDER_NIBBLE_SEQ_SUB_EN adds a SUB input giving OPA - OPB via ~OPB and carry-in 1.
module adder_nibble_seq #(
  parameter int NIBBLES = 4,
  localparam int W = 4 * NIBBLES,
  localparam int IW = $clog2(NIBBLES)
) (
  input  logic         CLK,
  input  logic         RST,
  input  logic         START,
  input  logic [W-1:0] OPA,
  input  logic [W-1:0] OPB,
  input  logic         CIN,
`ifdef ADDER_NIBBLE_SEQ_SUB_EN
  input  logic         SUB,
`endif
  output logic [W-1:0] SUM,
  output logic         COUT,
  output logic         BUSY,
  output logic         DONE,
  output logic [3:0]   ADD_A,
  output logic [3:0]   ADD_B,
  output logic         ADD_C0,
  input  logic [3:0]   ADD_F,
  input  logic         ADD_C4
);

  typedef enum logic {IDLE, RUN} state_t;

  localparam logic [IW-1:0] LAST = IW'(NIBBLES - 1);

  state_t        state, state_nx;
  logic [W-1:0]  opa_q, opb_q;
  logic [W-5:0]  acc_q;
  logic [IW-1:0] idx_q;
  logic          carry_q;
  logic [W-1:0]  sum_q;
  logic          cout_q, busy_q, done_q;
  logic          sub_q;
  logic          carry_init;

`ifdef ADDER_NIBBLE_SEQ_SUB_EN
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) sub_q <= 1'b0;
    else if (state == IDLE && START) sub_q <= SUB;
  end
  // Subtraction forces carry-in to 1 so that ~OPB + 1 forms the two's complement.
  assign carry_init = SUB ? 1'b1 : CIN;
`else
  assign sub_q      = 1'b0;
  assign carry_init = CIN;
`endif

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    ADD_A    = 4'h0;
    ADD_B    = 4'h0;
    ADD_C0   = 1'b0;
    case (state)
      IDLE: begin
        if (START) state_nx = RUN;
      end
      RUN: begin
        ADD_A  = opa_q[4*int'(idx_q) +: 4];
        ADD_B  = opb_q[4*int'(idx_q) +: 4] ^ {4{sub_q}};
        ADD_C0 = carry_q;
        if (idx_q == LAST) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      opa_q   <= '0;
      opb_q   <= '0;
      acc_q   <= '0;
      idx_q   <= '0;
      carry_q <= 1'b0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state)
        IDLE: begin
          if (START) begin
            opa_q   <= OPA;
            opb_q   <= OPB;
            carry_q <= carry_init;
            idx_q   <= '0;
            busy_q  <= 1'b1;
          end
        end
        RUN: begin
          carry_q <= ADD_C4;
          if (idx_q == LAST) begin
            // Top nibble goes straight to SUM; acc only ever holds the lower slices.
            sum_q  <= {ADD_F, acc_q};
            cout_q <= ADD_C4;
            done_q <= 1'b1;
            busy_q <= 1'b0;
          end else begin
            acc_q[4*int'(idx_q) +: 4] <= ADD_F;
            idx_q <= idx_q + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign SUM  = sum_q;
  assign COUT = cout_q;
  assign BUSY = busy_q;
  assign DONE = done_q;

endmodule

// File: tb/tb_adder_nibble_seq.sv
// Bench for adder_nibble_seq: behavioural latency/arithmetic model checked every cycle plus directed literals.
module tb_adder_nibble_seq;
  localparam int N = 4;
  localparam int W = 4 * N;

  logic         CLK, RST, START, CIN, SUB;
  logic [W-1:0] OPA, OPB, SUM;
  logic         COUT, BUSY, DONE, ADD_C0, ADD_C4;
  logic [3:0]   ADD_A, ADD_B, ADD_F;

  int checks = 0;
  int errors = 0;

  adder_nibble_seq #(.NIBBLES(N)) dut (
    .CLK(CLK), .RST(RST), .START(START), .OPA(OPA), .OPB(OPB), .CIN(CIN),
`ifdef ADDER_NIBBLE_SEQ_SUB_EN
    .SUB(SUB),
`endif
    .SUM(SUM), .COUT(COUT), .BUSY(BUSY), .DONE(DONE),
    .ADD_A(ADD_A), .ADD_B(ADD_B), .ADD_C0(ADD_C0), .ADD_F(ADD_F), .ADD_C4(ADD_C4)
  );

  // External 4-bit combinational adder
  assign {ADD_C4, ADD_F} = {1'b0, ADD_A} + {1'b0, ADD_B} + {4'h0, ADD_C0};

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: operation takes N cycles after acceptance, then result = a + b + c
  int           m_left = 0;
  logic [W-1:0] m_a = '0, m_b = '0, m_sum = '0;
  logic         m_c = 1'b0, m_cout = 1'b0, m_done = 1'b0;

  always @(posedge CLK or posedge RST) begin
    if (RST) begin
      m_left = 0; m_a = '0; m_b = '0; m_c = 1'b0;
      m_sum = '0; m_cout = 1'b0; m_done = 1'b0;
    end else begin
      m_done = 1'b0;
      if (m_left == 0) begin
        if (START) begin
          m_a = OPA;
          m_b = SUB ? ~OPB : OPB;
          m_c = SUB ? 1'b1 : CIN;
          m_left = N;
        end
      end else begin
        m_left--;
        if (m_left == 0) begin
          {m_cout, m_sum} = {1'b0, m_a} + {1'b0, m_b} + {{W{1'b0}}, m_c};
          m_done = 1'b1;
        end
      end
    end
  end

  function automatic logic exp_c0(int j);
    logic [W:0] mask, s;
    if (j == 0) return m_c;
    mask = ({{W{1'b0}}, 1'b1} << (4 * j)) - 1'b1;
    s = ({1'b0, m_a} & mask) + ({1'b0, m_b} & mask) + {{W{1'b0}}, m_c};
    return s[4*j];
  endfunction

  always @(negedge CLK) begin
    if (!RST) begin
      chk("busy", BUSY, m_left > 0);
      chk("done", DONE, m_done);
      chk("sum_hold", SUM, m_sum);
      chk("cout_hold", COUT, m_cout);
      if (m_left > 0) begin
        chk("add_a", ADD_A, m_a[4*(N-m_left) +: 4]);
        chk("add_b", ADD_B, m_b[4*(N-m_left) +: 4]);
        chk("add_c0", ADD_C0, exp_c0(N - m_left));
      end else begin
        chk("add_idle", {ADD_A, ADD_B, ADD_C0}, 9'h0);
      end
    end
  end

  logic [3:0] rec_a [N];
  logic       rec_c0 [N];

  task automatic run_op(input logic [W-1:0] a, b, input logic c, s,
                        input logic [W-1:0] es, input logic ec);
    int busy_n;
    bit seen;
    @(negedge CLK);
    OPA = a; OPB = b; CIN = c; SUB = s; START = 1'b1;
    busy_n = 0; seen = 0;
    for (int i = 1; i <= 20 && !seen; i++) begin
      @(negedge CLK);
      START = 1'b0; OPA = ~a; OPB = ~b; CIN = ~c;
      if (BUSY) begin
        if (busy_n < N) begin
          rec_a[busy_n] = ADD_A;
          rec_c0[busy_n] = ADD_C0;
        end
        busy_n++;
      end
      if (DONE) begin
        seen = 1;
        chk("latency", i, N + 1);
        chk("sum", SUM, es);
        chk("cout", COUT, ec);
        chk("busy_cycles", busy_n, N);
      end
    end
    if (!seen) chk("done_timeout", 0, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int ndone;
    int done_at [3];
    RST = 1'b1; START = 1'b0; OPA = '0; OPB = '0; CIN = 1'b0; SUB = 1'b0;
    repeat (2) @(negedge CLK);
    chk("rst_sum", SUM, 16'h0);
    chk("rst_cout", COUT, 0);
    chk("rst_busy", BUSY, 0);
    chk("rst_done", DONE, 0);
    RST = 1'b0;

    run_op(16'h0001, 16'h0000, 1'b0, 1'b0, 16'h0001, 1'b0);
    chk("seq_a0", rec_a[0], 4'h1);
    chk("seq_a1", rec_a[1], 4'h0);
    chk("seq_a2", rec_a[2], 4'h0);
    chk("seq_a3", rec_a[3], 4'h0);

    run_op(16'h0007, 16'h0003, 1'b1, 1'b0, 16'h000B, 1'b0);
    run_op(16'h0007, 16'h0003, 1'b0, 1'b0, 16'h000A, 1'b0);

    run_op(16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1);
    chk("seq_c0_0", rec_c0[0], 0);
    chk("seq_c0_1", rec_c0[1], 1);
    chk("seq_c0_2", rec_c0[2], 1);
    chk("seq_c0_3", rec_c0[3], 1);

    // START held high: a result every N+1 cycles; OPA glitch mid-run must not leak in
    @(negedge CLK);
    OPA = 16'h1234; OPB = 16'h1111; CIN = 1'b0; START = 1'b1;
    ndone = 0;
    for (int i = 1; i <= 16; i++) begin
      @(negedge CLK);
      if (i == 2) OPA = 16'hFFFF;
      if (i == 4) OPA = 16'h1234;
      if (DONE) begin
        if (ndone < 3) done_at[ndone] = i;
        chk("b2b_sum", SUM, 16'h2345);
        ndone++;
      end
    end
    START = 1'b0;
    chk("b2b_count", ndone, 3);
    chk("b2b_done0", done_at[0], 5);
    chk("b2b_done1", done_at[1], 10);
    chk("b2b_done2", done_at[2], 15);
    repeat (6) @(negedge CLK);

    // Reset in the middle of an operation
    @(negedge CLK);
    OPA = 16'h00FF; OPB = 16'h0001; CIN = 1'b0; START = 1'b1;
    @(negedge CLK);
    START = 1'b0;
    repeat (2) @(negedge CLK);
    chk("rst_mid_pre_busy", BUSY, 1);
    RST = 1'b1;
    #1;
    chk("rst_mid_busy", BUSY, 0);
    chk("rst_mid_done", DONE, 0);
    chk("rst_mid_sum", SUM, 16'h0);
    chk("rst_mid_cout", COUT, 0);
    chk("rst_mid_add_a", ADD_A, 4'h0);
    @(negedge CLK);
    RST = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge CLK);
      chk("rst_mid_no_done", DONE, 0);
    end
    run_op(16'h0002, 16'h0003, 1'b0, 1'b0, 16'h0005, 1'b0);

`ifdef ADDER_NIBBLE_SEQ_SUB_EN
    run_op(16'h0007, 16'h0003, 1'b0, 1'b1, 16'h0004, 1'b1);
    run_op(16'h0003, 16'h0007, 1'b1, 1'b1, 16'hFFFC, 1'b0);
    run_op(16'h0007, 16'h0003, 1'b0, 1'b0, 16'h000A, 1'b0);
`endif

    repeat (3) @(negedge CLK);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
